muldiv_unit: RTL

Parametrised multi-cycle integer multiply/divide unit executing the RV32M `OP` instructions (funct7 = 7'b0000001) alongside the single-cycle ALU in the execute stage. It accepts one operation at a time through a start/busy/done handshake, iterates over XLEN cycles for divides and, by default, for multiplies, and applies correct two's-complement signed handling and RISC-V corner-case results. Decode steers M-extension instructions here and stalls the pipeline while `busy` is high.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with a start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to replace iterative multiplies with a single registered multiplier.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] busA,
    input  logic [XLEN-1:0] busB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] busC
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    logic              is_div;
    logic              is_rem;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              neg_next;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              bypass;
    logic [XLEN-1:0]   bypass_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     shifted;
    logic              fits;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_val;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_p;
`endif

    // Launch decode: magnitudes, result sign, and the cases answered without iterating.
    always_comb begin
        is_div   = funct3[2];
        is_rem   = funct3[2] & funct3[1];
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (is_div && !funct3[0]);
        b_signed = (funct3 == 3'b001) || (is_div && !funct3[0]);
        a_neg    = a_signed && busA[XLEN-1];
        b_neg    = b_signed && busB[XLEN-1];
        mag_a    = a_neg ? -busA : busA;
        mag_b    = b_neg ? -busB : busB;
        neg_next = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (busB == '0);
        div_ovf  = is_div && !funct3[0] && (busA == {1'b1, {(XLEN-1){1'b0}}}) && (busB == '1);
        bypass   = div_zero || div_ovf;
        if (div_zero)
            bypass_val = funct3[1] ? busA : '1;
        else
            bypass_val = funct3[1] ? '0 : busA;
`ifdef MULDIV_FAST_MUL_EN
        fast_a = {a_signed & busA[XLEN-1], busA};
        fast_b = {b_signed & busB[XLEN-1], busB};
        fast_p = fast_a * fast_b;
        if (!is_div) begin
            bypass     = 1'b1;
            bypass_val = (funct3 == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
        end
`endif
    end

    // hi/lo double as product accumulator (multiply) or remainder/quotient (divide).
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted  = {hi, lo[XLEN-1]};
        fits     = shifted >= {1'b0, opnd};
        diff     = shifted[XLEN-1:0] - opnd;
        prod_fix = neg ? -{hi, lo} : {hi, lo};
        if (!op[2])
            fix_val = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (op[1])
            fix_val = neg ? -hi : hi;
        else
            fix_val = neg ? -lo : lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            busC  <= '0;
            op    <= '0;
            neg   <= 1'b0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op  <= funct3;
                        neg <= neg_next;
                        if (bypass) begin
                            busC  <= bypass_val;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            opnd  <= mag_b;
                            hi    <= '0;
                            lo    <= mag_a;
                            cnt   <= CNT_W'(XLEN);
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (op[2]) begin
                        hi <= fits ? diff : shifted[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], fits};
                    end else begin
                        {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= FIX;
                end
                FIX: begin
                    busC  <= fix_val;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
